// File: rtl/regfile_alloc_ctrl_pkg.sv
// Shared helpers for the register-file allocation controller.
package regfile_alloc_ctrl_pkg;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_alloc_ctrl_find_first_one_index.sv
// Priority picker: returns the one-hot of the lowest set bit of a vector.
module find_first_one_index
  import regfile_alloc_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vector_in,
  output logic [WIDTH-1:0] one_hot_out
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    one_hot_out = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vector_in[i]) begin
        one_hot_out    = '0;
        one_hot_out[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_alloc_ctrl.sv
// Allocation / release / CAM-lookup controller sitting in front of a
// tri-port tag register file. Occupancy lives only in valid_q.
module regfile_alloc_ctrl
  import regfile_alloc_ctrl_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
  parameter int NUMBER_ENTRY              = 4,
  localparam int COUNT_W                  = clog2(NUMBER_ENTRY) + 1
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 alloc_valid_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] alloc_tag_in,
  output logic                                 alloc_ready_out,
  output logic [NUMBER_ENTRY-1:0]              alloc_entry_decoded_out,
  input  logic                                 lookup_valid_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lookup_tag_in,
  output logic                                 lookup_done_out,
  output logic                                 lookup_hit_out,
  output logic                                 lookup_multi_hit_out,
  output logic [NUMBER_ENTRY-1:0]              lookup_entry_decoded_out,
  input  logic                                 release_en_in,
  input  logic [NUMBER_ENTRY-1:0]              release_entry_decoded_in,
  input  logic                                 flush_in,
  output logic                                 rf_write_en_out,
  output logic                                 rf_cam_en_out,
  output logic [NUMBER_ENTRY-1:0]              rf_write_entry_addr_decoded_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rf_write_entry_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rf_cam_entry_out,
  input  logic [NUMBER_ENTRY-1:0]              rf_cam_result_decoded_in,
  output logic [NUMBER_ENTRY-1:0]              valid_vector_out,
  output logic [COUNT_W-1:0]                   count_out,
  output logic                                 full_out,
  output logic                                 empty_out
);

  logic [NUMBER_ENTRY-1:0] valid_q, valid_d;
  logic                    lookup_pending_q, lookup_pending_d;
  logic [NUMBER_ENTRY-1:0] lookup_mask_q, lookup_mask_d;

  logic [NUMBER_ENTRY-1:0] free_one_hot;
  logic [NUMBER_ENTRY-1:0] match_vector;
  logic [NUMBER_ENTRY-1:0] match_one_hot;
  logic [COUNT_W-1:0]      valid_count;
  logic [COUNT_W-1:0]      match_count;
  logic                    alloc_fire;

  find_first_one_index #(.WIDTH(NUMBER_ENTRY)) u_free_pick (
    .vector_in   (~valid_q),
    .one_hot_out (free_one_hot)
  );

  find_first_one_index #(.WIDTH(NUMBER_ENTRY)) u_match_pick (
    .vector_in   (match_vector),
    .one_hot_out (match_one_hot)
  );

  // Population counts of occupancy and of the masked CAM result.
  always_comb begin
    valid_count = '0;
    match_count = '0;
    for (int i = 0; i < NUMBER_ENTRY; i++) begin
      valid_count = valid_count + COUNT_W'(valid_q[i]);
      match_count = match_count + COUNT_W'(match_vector[i]);
    end
  end

  // Allocation handshake and register-file write/CAM port drive.
  always_comb begin
    full_out                        = &valid_q;
    empty_out                       = ~|valid_q;
    count_out                       = valid_count;
    valid_vector_out                = valid_q;
    alloc_ready_out                 = ~full_out;
    alloc_entry_decoded_out         = alloc_ready_out ? free_one_hot : '0;
    alloc_fire                      = alloc_valid_in && alloc_ready_out && !flush_in && !reset_in;
    rf_write_en_out                 = alloc_fire;
    rf_write_entry_addr_decoded_out = alloc_fire ? alloc_entry_decoded_out : '0;
    rf_write_entry_out              = alloc_tag_in;
    rf_cam_en_out                   = lookup_valid_in && !reset_in;
    rf_cam_entry_out                = lookup_tag_in;
  end

  // Lookup result: regfile CAM output filtered by the occupancy snapshot.
  always_comb begin
    lookup_done_out          = lookup_pending_q && !reset_in;
    match_vector             = lookup_done_out ? (rf_cam_result_decoded_in & lookup_mask_q) : '0;
    lookup_hit_out           = |match_vector;
    lookup_entry_decoded_out = match_one_hot;
    lookup_multi_hit_out     = match_count > COUNT_W'(1);
  end

  // Next-state: flush wins, otherwise release and allocate both apply.
  always_comb begin
    valid_d = valid_q;
    if (release_en_in) begin
      valid_d = valid_d & ~release_entry_decoded_in;
    end
    valid_d = valid_d | rf_write_entry_addr_decoded_out;
    if (flush_in) begin
      valid_d = '0;
    end
    lookup_pending_d = lookup_valid_in;
    lookup_mask_d    = valid_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_q          <= '0;
      lookup_pending_q <= 1'b0;
      lookup_mask_q    <= '0;
    end else begin
      valid_q          <= valid_d;
      lookup_pending_q <= lookup_pending_d;
      lookup_mask_q    <= lookup_mask_d;
    end
  end

endmodule

// File: tb/tb_regfile_alloc_ctrl.sv
// Bench for regfile_alloc_ctrl with a behavioural tri-port tag regfile.
module tb_regfile_alloc_ctrl;

  logic       clk;
  logic       reset;
  logic       alloc_valid;
  logic [7:0] alloc_tag;
  logic       alloc_ready;
  logic [3:0] alloc_entry;
  logic       lookup_valid;
  logic [7:0] lookup_tag;
  logic       lookup_done;
  logic       lookup_hit;
  logic       lookup_multi;
  logic [3:0] lookup_entry;
  logic       release_en;
  logic [3:0] release_vec;
  logic       flush;
  logic       rf_write_en;
  logic       rf_cam_en;
  logic [3:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic [7:0] rf_cam_data;
  logic [3:0] rf_cam_result;
  logic [3:0] valid_vector;
  logic [2:0] count;
  logic       full;
  logic       empty;

  logic [7:0] rf_mem [4];

  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] atag;
    logic       lv;
    logic [7:0] ltag;
    logic       ren;
    logic [3:0] rel;
    logic       fl;
    logic [3:0] exp_ae;
    logic       exp_wr;
    logic       exp_rdy;
    logic [2:0] exp_cnt;
    logic [3:0] exp_valid;
    logic       exp_hit;
    logic [3:0] exp_lk_entry;
    logic       exp_multi;
  } vec_t;

  typedef struct {
    logic       hit;
    logic [3:0] entry;
    logic       multi;
  } lk_exp_t;

  vec_t    vecs[$];
  lk_exp_t sb[$];
  int      checks;
  int      errors;
  int      cur_row;

  regfile_alloc_ctrl #(
    .SINGLE_ENTRY_SIZE_IN_BITS(8),
    .NUMBER_ENTRY(4)
  ) dut (
    .clk_in                          (clk),
    .reset_in                        (reset),
    .alloc_valid_in                  (alloc_valid),
    .alloc_tag_in                    (alloc_tag),
    .alloc_ready_out                 (alloc_ready),
    .alloc_entry_decoded_out         (alloc_entry),
    .lookup_valid_in                 (lookup_valid),
    .lookup_tag_in                   (lookup_tag),
    .lookup_done_out                 (lookup_done),
    .lookup_hit_out                  (lookup_hit),
    .lookup_multi_hit_out            (lookup_multi),
    .lookup_entry_decoded_out        (lookup_entry),
    .release_en_in                   (release_en),
    .release_entry_decoded_in        (release_vec),
    .flush_in                        (flush),
    .rf_write_en_out                 (rf_write_en),
    .rf_cam_en_out                   (rf_cam_en),
    .rf_write_entry_addr_decoded_out (rf_write_addr),
    .rf_write_entry_out              (rf_write_data),
    .rf_cam_entry_out                (rf_cam_data),
    .rf_cam_result_decoded_in        (rf_cam_result),
    .valid_vector_out                (valid_vector),
    .count_out                       (count),
    .full_out                        (full),
    .empty_out                       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag storage with a write port and a CAM port whose result is registered.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
      rf_cam_result <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rf_write_en && rf_write_addr[i]) rf_mem[i] <= rf_write_data;
        rf_cam_result[i] <= rf_cam_en && (rf_mem[i] == rf_cam_data);
      end
    end
  end

  function automatic vec_t mk(
    input logic rst, input logic av, input logic [7:0] atag,
    input logic lv, input logic [7:0] ltag,
    input logic ren, input logic [3:0] rel, input logic fl,
    input logic [3:0] exp_ae, input logic exp_wr, input logic exp_rdy,
    input logic [2:0] exp_cnt, input logic [3:0] exp_valid,
    input logic exp_hit, input logic [3:0] exp_lk_entry, input logic exp_multi);
    vec_t v;
    v.rst = rst; v.av = av; v.atag = atag; v.lv = lv; v.ltag = ltag;
    v.ren = ren; v.rel = rel; v.fl = fl;
    v.exp_ae = exp_ae; v.exp_wr = exp_wr; v.exp_rdy = exp_rdy;
    v.exp_cnt = exp_cnt; v.exp_valid = exp_valid;
    v.exp_hit = exp_hit; v.exp_lk_entry = exp_lk_entry; v.exp_multi = exp_multi;
    return v;
  endfunction

  task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL row %0d %s: got 0x%0h expected 0x%0h", cur_row, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset        = v.rst;
    alloc_valid  = v.av;
    alloc_tag    = v.atag;
    lookup_valid = v.lv;
    lookup_tag   = v.ltag;
    release_en   = v.ren;
    release_vec  = v.rel;
    flush        = v.fl;
  endtask

  // Compare at the falling edge; lookup results come from the scoreboard.
  task automatic checkOutput(input vec_t v);
    logic    exp_done;
    lk_exp_t e;
    @(negedge clk);
    exp_done = (sb.size() != 0) && !v.rst;
    if (v.rst) sb.delete();
    compareField("lookup_done", 32'(lookup_done), 32'(exp_done));
    if (exp_done) begin
      e = sb.pop_front();
      compareField("lookup_hit", 32'(lookup_hit), 32'(e.hit));
      compareField("lookup_entry", 32'(lookup_entry), 32'(e.entry));
      compareField("lookup_multi", 32'(lookup_multi), 32'(e.multi));
    end else begin
      compareField("lookup_hit_idle", 32'(lookup_hit), 32'(0));
      compareField("lookup_entry_idle", 32'(lookup_entry), 32'(0));
    end
    compareField("alloc_ready", 32'(alloc_ready), 32'(v.exp_rdy));
    compareField("alloc_entry", 32'(alloc_entry), 32'(v.exp_ae));
    compareField("rf_write_en", 32'(rf_write_en), 32'(v.exp_wr));
    compareField("rf_write_addr", 32'(rf_write_addr), v.exp_wr ? 32'(v.exp_ae) : 32'(0));
    if (v.exp_wr) compareField("rf_write_data", 32'(rf_write_data), 32'(v.atag));
    compareField("rf_cam_en", 32'(rf_cam_en), 32'(v.lv && !v.rst));
    if (v.lv && !v.rst) compareField("rf_cam_data", 32'(rf_cam_data), 32'(v.ltag));
    compareField("valid_vector", 32'(valid_vector), 32'(v.exp_valid));
    compareField("count", 32'(count), 32'(v.exp_cnt));
    compareField("full", 32'(full), 32'(v.exp_cnt == 3'd4));
    compareField("empty", 32'(empty), 32'(v.exp_cnt == 3'd0));
    if (v.lv && !v.rst) begin
      e.hit   = v.exp_hit;
      e.entry = v.exp_lk_entry;
      e.multi = v.exp_multi;
      sb.push_back(e);
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    checkOutput(v);
    cur_row = cur_row + 1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cur_row      = 0;
    reset        = 1'b1;
    alloc_valid  = 1'b0;
    alloc_tag    = 8'h00;
    lookup_valid = 1'b0;
    lookup_tag   = 8'h00;
    release_en   = 1'b0;
    release_vec  = 4'b0000;
    flush        = 1'b0;
    repeat (2) @(posedge clk);

    //            rst av atag  lv ltag  ren rel     fl  ae      wr rdy cnt   valid    hit lkent   mul
    vecs.push_back(mk(1, 1, 8'h11, 1, 8'h11, 0, 4'b0000, 0, 4'b0001, 0, 1, 3'd0, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 4'b0000, 0, 4'b0001, 1, 1, 3'd0, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 8'h00, 0, 4'b0000, 0, 4'b0010, 1, 1, 3'd1, 4'b0001, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 8'h00, 0, 4'b0000, 0, 4'b0100, 1, 1, 3'd2, 4'b0011, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 8'h00, 0, 4'b0000, 0, 4'b1000, 1, 1, 3'd3, 4'b0111, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h55, 0, 8'h00, 1, 4'b0010, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h55, 0, 8'h00, 0, 4'b0000, 0, 4'b0010, 1, 1, 3'd3, 4'b1101, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h33, 0, 4'b0000, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 1, 4'b0100, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h99, 0, 4'b0000, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h11, 1, 4'b0001, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 1, 4'b0001, 0));
    vecs.push_back(mk(0, 1, 8'h66, 1, 8'h66, 0, 4'b0000, 0, 4'b0001, 1, 1, 3'd3, 4'b1110, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h66, 0, 4'b0000, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 1, 4'b0001, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 4'b0101, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h77, 0, 8'h00, 0, 4'b0000, 0, 4'b0001, 1, 1, 3'd2, 4'b1010, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h77, 0, 8'h00, 0, 4'b0000, 0, 4'b0100, 1, 1, 3'd3, 4'b1011, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h77, 0, 4'b0000, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 1, 4'b0001, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 4'b1000, 0, 4'b0000, 0, 0, 3'd4, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'h88, 0, 8'h00, 0, 4'b0000, 1, 4'b1000, 0, 1, 3'd3, 4'b0111, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h77, 0, 4'b0000, 0, 4'b0001, 0, 1, 3'd0, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 4'b0001, 0, 1, 3'd0, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'hA1, 0, 8'h00, 0, 4'b0000, 0, 4'b0001, 1, 1, 3'd0, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 8'hB2, 1, 8'hA1, 0, 4'b0000, 0, 4'b0010, 1, 1, 3'd1, 4'b0001, 1, 4'b0001, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'hB2, 0, 4'b0000, 0, 4'b0100, 0, 1, 3'd2, 4'b0011, 1, 4'b0010, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'hA1, 0, 4'b0000, 0, 4'b0100, 0, 1, 3'd2, 4'b0011, 1, 4'b0001, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 4'b0100, 0, 1, 3'd2, 4'b0011, 0, 4'b0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i]);
    end

    // Lookup, then reset the following cycle: the pending result must vanish.
    runVec(mk(0, 0, 8'h00, 1, 8'hA1, 0, 4'b0000, 0, 4'b0100, 0, 1, 3'd2, 4'b0011, 1, 4'b0001, 0));
    runVec(mk(1, 0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 4'b0100, 0, 1, 3'd2, 4'b0011, 0, 4'b0000, 0));
    runVec(mk(0, 0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 4'b0001, 0, 1, 3'd0, 4'b0000, 0, 4'b0000, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
